// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the memory stage and the data-memory responder
interface dmem_responder_if;
  logic req_valid;
  logic req_we;
  logic [3:0] req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic req_ready;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_err;
  logic busy;
  modport master(
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input req_ready, resp_valid, resp_rdata, resp_err, busy
  );
  modport slave(
    input req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with configurable wait states
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nextState;
  logic [3:0] waitCnt;
  logic [AW+1:0] addrQ, curAddr;
  logic weQ, curWe;
  logic [3:0] beQ, curBe;
  logic [31:0] wdataQ, curWdata, rdataQ;
  logic errQ, misaligned, commit;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  // In IDLE the live request is used so a zero-wait transaction can commit on its acceptance edge
  always_comb begin
    curAddr = state == IDLE ? bus.req_addr[AW+1:0] : addrQ;
    curWe = state == IDLE ? bus.req_we : weQ;
    curBe = state == IDLE ? bus.req_be : beQ;
    curWdata = state == IDLE ? bus.req_wdata : wdataQ;
    idx = curAddr[AW+1:2];
    misaligned = (curBe == 4'hF && curAddr[1:0] != 2'b00) ||
                 ((curBe == 4'h3 || curBe == 4'hC) && curAddr[0]);
    nextState = state == IDLE ? (bus.req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (waitCnt == 4'd0 ? RESP : WAIT) : IDLE;
    commit = reset && nextState == RESP && state != RESP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      waitCnt <= '0;
      addrQ <= '0;
      weQ <= 1'b0;
      beQ <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      errQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.req_valid) begin
        addrQ <= bus.req_addr[AW+1:0];
        weQ <= bus.req_we;
        beQ <= bus.req_be;
        wdataQ <= bus.req_wdata;
        waitCnt <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (commit) begin
        rdataQ <= misaligned ? '0 : mem[idx];
        errQ <= misaligned;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (commit && curWe && !misaligned)
      for (int i = 0; i < 4; i++)
        if (curBe[i]) mem[idx][8*i +: 8] <= curWdata[8*i +: 8];
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.busy = state != IDLE;
  assign bus.resp_rdata = rdataQ;
  assign bus.resp_err = errQ;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of latency, byte lanes, alignment, wrap, reset abort and zero-wait streaming
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  dmem_responder_if bus0();
  dmem_responder_if bus1();
  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    chk1("ready_idle", bus0.req_ready, 1'b1);
    bus0.req_valid = 1'b1;
    bus0.req_we = we;
    bus0.req_be = be;
    bus0.req_addr = addr;
    bus0.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    chk1("ready_fall", bus0.req_ready, 1'b0);
    chk1("busy_wait", bus0.busy, 1'b1);
    lat = 1;
    while (!bus0.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    rdata = bus0.resp_rdata;
    err = bus0.resp_err;
    @(negedge clk);
    chk1("pulse_once", bus0.resp_valid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] rd;
    logic er;
    int n;
    int prevAcc;
    int acc;
    logic [3:0] vBe [4];
    logic vWe [4];
    logic [31:0] vAddr [4];
    logic [31:0] vWdata [4];
    logic [31:0] vExp [4];
    logic vLoad [4];
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = '0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_be = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", bus0.busy, 1'b0);
    chk1("rst_resp_valid", bus0.resp_valid, 1'b0);
    chk("rst_rdata", bus0.resp_rdata, 32'h0);
    chk1("rst_err", bus0.resp_err, 1'b0);
    reset = 1'b1;
    #1 chk1("rst_ready", bus0.req_ready, 1'b1);
    xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er);
    chk1("sw_err", er, 1'b0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk1("lw_err", er, 1'b0);
    xact(1'b1, 4'b0100, 32'h12, 32'h00AA0000, rd, er);
    chk1("sb_err", er, 1'b0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("sb_data", rd, 32'hDEAABEEF);
    xact(1'b0, 4'hF, 32'h11, 32'h0, rd, er);
    chk1("mis_lw_err", er, 1'b1);
    chk("mis_lw_data", rd, 32'h0);
    xact(1'b1, 4'h3, 32'h11, 32'hFFFFFFFF, rd, er);
    chk1("mis_sh_err", er, 1'b1);
    chk("mis_sh_data", rd, 32'h0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("after_mis", rd, 32'hDEAABEEF);
    chk1("after_mis_err", er, 1'b0);
    xact(1'b1, 4'b0110, 32'h10, 32'h11223344, rd, er);
    chk1("odd_be_err", er, 1'b0);
    xact(1'b1, 4'hC, 32'h12, 32'h55660000, rd, er);
    chk1("sh_hi_err", er, 1'b0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er);
    chk("lanes_data", rd, 32'h556633EF);
    xact(1'b1, 4'hF, 32'h100, 32'h12345678, rd, er);
    xact(1'b0, 4'hF, 32'h0, 32'h0, rd, er);
    chk("wrap_data", rd, 32'h12345678);
    xact(1'b1, 4'hF, 32'h20, 32'h11112222, rd, er);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_be = 4'hF;
    bus0.req_addr = 32'h20; bus0.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    chk1("pre_abort_busy", bus0.busy, 1'b1);
    reset = 1'b0;
    #1 chk1("abort_busy", bus0.busy, 1'b0);
    chk1("abort_resp", bus0.resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.resp_valid) n++;
    end
    chk("abort_no_resp", 32'(n), 32'd0);
    xact(1'b0, 4'hF, 32'h20, 32'h0, rd, er);
    chk("abort_mem", rd, 32'h11112222);
    vWe[0] = 1'b1; vBe[0] = 4'hF; vAddr[0] = 32'h8; vWdata[0] = 32'hA5A5A5A5; vLoad[0] = 1'b0; vExp[0] = 32'h0;
    vWe[1] = 1'b1; vBe[1] = 4'h0; vAddr[1] = 32'h8; vWdata[1] = 32'hFFFFFFFF; vLoad[1] = 1'b0; vExp[1] = 32'h0;
    vWe[2] = 1'b0; vBe[2] = 4'hF; vAddr[2] = 32'h8; vWdata[2] = 32'h0; vLoad[2] = 1'b1; vExp[2] = 32'hA5A5A5A5;
    vWe[3] = 1'b0; vBe[3] = 4'h1; vAddr[3] = 32'h9; vWdata[3] = 32'h0; vLoad[3] = 1'b1; vExp[3] = 32'hA5A5A5A5;
    prevAcc = 0;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus1.req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk1("w0_ready", bus1.req_ready, 1'b1);
      chk1("w0_gap", bus1.resp_valid, 1'b0);
      bus1.req_we = vWe[i]; bus1.req_be = vBe[i]; bus1.req_addr = vAddr[i]; bus1.req_wdata = vWdata[i];
      @(posedge clk);
      #1 acc = cyc;
      if (i > 0) chk("w0_interval", 32'(acc - prevAcc), 32'd2);
      prevAcc = acc;
      @(negedge clk);
      chk1("w0_resp", bus1.resp_valid, 1'b1);
      chk1("w0_err", bus1.resp_err, 1'b0);
      if (vLoad[i]) chk("w0_rdata", bus1.resp_rdata, vExp[i]);
    end
    bus1.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
